// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states and
// default datapath widths.
package mau_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADDM  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store/read-modify-write sequencer between the execute stage and an
// 8-bit data memory with one-cycle registered read latency.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// RD    | mem_read high for one cycle at the effective address
// CAP   | read data available; capture old value, form the write value
// WR    | mem_write high for one cycle
// RESP  | resp_valid pulse with resp_data/resp_carry
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_carry,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state, state_nxt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic              carry_q;
  logic              accept;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W:0]   sum;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign ea        = req_base + req_offset;
  assign sum       = {1'b0, mem_rdata} + {1'b0, wdata_q};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (req_op == OP_STORE) ? WR : RD;
      RD:   state_nxt = CAP;
      CAP:  state_nxt = (op_q == OP_LOAD) ? RESP : WR;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory strobes and the response are registered off the next state so
  // they line up exactly with the RD/WR/RESP cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_LOAD;
      wdata_q     <= '0;
      old_q       <= '0;
      carry_q     <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_carry  <= 1'b0;
    end else begin
      mem_read   <= (state_nxt == RD);
      mem_write  <= (state_nxt == WR);
      resp_valid <= (state_nxt == RESP);

      if (accept) begin
        op_q        <= req_op;
        wdata_q     <= req_wdata;
        mem_address <= ea;
        if (req_op == OP_STORE) mem_wdata <= req_wdata;
      end

      if (state == CAP) begin
        old_q   <= mem_rdata;
        carry_q <= (op_q == OP_ADDM) && sum[DATA_W];
        if (op_q == OP_ADDM)      mem_wdata <= sum[DATA_W-1:0];
        else if (op_q == OP_SWAP) mem_wdata <= wdata_q;
        if (op_q == OP_LOAD) begin
          resp_data  <= mem_rdata;
          resp_carry <= 1'b0;
        end
      end

      if (state == WR) begin
        resp_data  <= (op_q == OP_STORE) ? wdata_q : old_q;
        resp_carry <= (op_q == OP_ADDM) ? carry_q : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural data memory
// (registered one-cycle read) and a high-level reference model.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_base = 8'h00;
  logic [7:0] req_offset = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_carry;
  logic [7:0] mem_address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_carry(resp_carry),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_address];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    mem[a] <= d;
    ref_mem[a] = d;
  endtask

  // Reference behaviour of one request given the old memory contents.
  function automatic void model(input logic [1:0] op, input logic [7:0] old, input logic [7:0] wd,
                                output logic [7:0] resp, output logic carry,
                                output logic [7:0] nv, output int lat);
    int s;
    s = int'(old) + int'(wd);
    carry = 1'b0;
    resp = old;
    nv = old;
    lat = 4;
    case (op)
      OP_LOAD:  lat = 3;
      OP_STORE: begin resp = wd; nv = wd; lat = 2; end
      OP_ADDM:  begin nv = s[7:0]; carry = (s > 255); end
      default:  nv = wd;
    endcase
  endfunction

  task automatic run_req(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] wd,
                         output int lat, output int rd_cnt, output int wr_cnt,
                         output int rd_cyc, output int wr_cyc, output int overlap, output int resp_cnt,
                         output logic [7:0] rd_addr, output logic [7:0] wr_addr,
                         output logic [7:0] wr_data, output logic [7:0] rdata, output logic carry);
    int guard = 0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; overlap = 0; resp_cnt = 0;
    rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00; rdata = 8'h00; carry = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_base = base; req_offset = off; req_wdata = wd;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_read) begin rd_cnt++; rd_cyc = c; rd_addr = mem_address; end
      if (mem_write) begin wr_cnt++; wr_cyc = c; wr_addr = mem_address; wr_data = mem_wdata; end
      if (mem_read && mem_write) overlap++;
      if (resp_valid) begin
        resp_cnt++;
        if (lat == 0) begin lat = c; rdata = resp_data; carry = resp_carry; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_carry, mem_read, mem_write} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, resp_valid, resp_carry, mem_read, mem_write});
    end
    n_tests++;
    if ({resp_data, mem_address, mem_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 000000", {resp_data, mem_address, mem_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_load();
    int lat, rc, wc, rcy, wcy, ov, rn;
    logic [7:0] ra, wa, wdv, rd;
    logic cy;
    poke(8'h05, 8'h03);
    run_req(OP_LOAD, 8'h00, 8'h05, 8'h00, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
    n_tests++;
    if (rc !== 1 || ra !== 8'h05) begin n_fail++; $display("FAIL load_read: got cnt=%0d addr=%h expected cnt=1 addr=05", rc, ra); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d expected 3", lat); end
    n_tests++;
    if (rd !== 8'h03 || cy !== 1'b0) begin n_fail++; $display("FAIL load_resp: got %h/%b expected 03/0", rd, cy); end
  endtask

  task automatic test_store();
    int lat, rc, wc, rcy, wcy, ov, rn;
    logic [7:0] ra, wa, wdv, rd;
    logic cy;
    run_req(OP_STORE, 8'hF0, 8'h20, 8'hA5, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
    ref_mem[8'h10] = 8'hA5;
    n_tests++;
    if (wc !== 1 || rc !== 0 || wa !== 8'h10 || wdv !== 8'hA5) begin
      n_fail++;
      $display("FAIL store_write: got wr=%0d rd=%0d addr=%h data=%h expected 1/0/10/a5", wc, rc, wa, wdv);
    end
    n_tests++;
    if (lat !== 2 || rd !== 8'hA5) begin n_fail++; $display("FAIL store_resp: got lat=%0d data=%h expected 2/a5", lat, rd); end
    run_req(OP_LOAD, 8'h08, 8'h08, 8'h00, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
    n_tests++;
    if (rd !== 8'hA5) begin n_fail++; $display("FAIL store_readback: got %h expected a5", rd); end
  endtask

  task automatic test_addm();
    int lat, rc, wc, rcy, wcy, ov, rn;
    logic [7:0] ra, wa, wdv, rd;
    logic cy;
    poke(8'h02, 8'hF0);
    run_req(OP_ADDM, 8'h01, 8'h01, 8'h20, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
    ref_mem[8'h02] = 8'h10;
    n_tests++;
    if (rd !== 8'hF0 || cy !== 1'b1 || lat !== 4) begin
      n_fail++;
      $display("FAIL addm_resp: got data=%h carry=%b lat=%0d expected f0/1/4", rd, cy, lat);
    end
    n_tests++;
    if (rcy !== 1 || wcy !== 3 || rc !== 1 || wc !== 1 || ov !== 0) begin
      n_fail++;
      $display("FAIL addm_sequence: got rd@%0d wr@%0d rd=%0d wr=%0d ov=%0d expected 1/3/1/1/0", rcy, wcy, rc, wc, ov);
    end
    n_tests++;
    if (mem[8'h02] !== 8'h10) begin n_fail++; $display("FAIL addm_mem: got %h expected 10", mem[8'h02]); end
  endtask

  task automatic test_swap();
    int lat, rc, wc, rcy, wcy, ov, rn;
    logic [7:0] ra, wa, wdv, rd;
    logic cy;
    poke(8'h03, 8'h12);
    run_req(OP_SWAP, 8'h00, 8'h03, 8'h77, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
    ref_mem[8'h03] = 8'h77;
    n_tests++;
    if (rd !== 8'h12 || cy !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL swap_resp: got data=%h carry=%b lat=%0d expected 12/0/4", rd, cy, lat);
    end
    n_tests++;
    if (mem[8'h03] !== 8'h77 || wdv !== 8'h77) begin
      n_fail++;
      $display("FAIL swap_mem: got mem=%h wdata=%h expected 77/77", mem[8'h03], wdv);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0, resp_cnt = 0, ready_busy = 0, b_acc = 0, resp1 = 0, resp2 = 0;
    logic [7:0] d2 = 8'h00;
    poke(8'h20, 8'h85);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADDM; req_base = 8'h10; req_offset = 8'h10; req_wdata = 8'h9C;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin req_op = OP_LOAD; req_base = 8'h20; req_offset = 8'h00; req_wdata = 8'h00; end
      if (b_acc != 0 && c > b_acc) req_valid = 1'b0;
      if (req_ready && c <= 4) ready_busy++;
      if (req_ready && b_acc == 0) b_acc = c;
      if (resp_valid) begin
        resp_cnt++;
        if (resp1 == 0) resp1 = c;
        else if (resp2 == 0) begin resp2 = c; d2 = resp_data; end
      end
    end
    req_valid = 1'b0;
    ref_mem[8'h20] = 8'h21;
    n_tests++;
    if (ready_busy !== 0 || resp1 !== 4) begin
      n_fail++;
      $display("FAIL b2b_first: got ready_while_busy=%0d resp@%0d expected 0/4", ready_busy, resp1);
    end
    n_tests++;
    if (b_acc !== 5 || resp2 !== 8 || resp_cnt !== 2) begin
      n_fail++;
      $display("FAIL b2b_second: got accept@%0d resp@%0d count=%0d expected 5/8/2", b_acc, resp2, resp_cnt);
    end
    n_tests++;
    if (d2 !== 8'h21 || mem[8'h20] !== 8'h21) begin
      n_fail++;
      $display("FAIL b2b_data: got resp=%h mem=%h expected 21/21", d2, mem[8'h20]);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0, wr_seen = 0, rv_seen = 0;
    poke(8'h04, 8'h23);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADDM; req_base = 8'h02; req_offset = 8'h02; req_wdata = 8'hFF;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd: got %b expected 1", mem_read); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({req_ready, resp_valid, resp_carry, mem_read, mem_write} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got %b expected 10000", {req_ready, resp_valid, resp_carry, mem_read, mem_write});
    end
    n_tests++;
    if ({resp_data, mem_address, mem_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h expected 000000", {resp_data, mem_address, mem_wdata});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
      if (resp_valid) rv_seen++;
    end
    n_tests++;
    if (wr_seen !== 0 || rv_seen !== 0 || mem[8'h04] !== 8'h23) begin
      n_fail++;
      $display("FAIL rstmid_abort: got writes=%0d resps=%0d mem=%h expected 0/0/23", wr_seen, rv_seen, mem[8'h04]);
    end
  endtask

  task automatic test_random();
    int lat, rc, wc, rcy, wcy, ov, rn, e_lat;
    logic [7:0] ra, wa, wdv, rd, base, off, wd, ea, e_resp, e_new;
    logic [1:0] op;
    logic cy, e_carry;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      base = 8'($urandom);
      off = 8'($urandom);
      wd = 8'($urandom);
      ea = 8'((int'(base) + int'(off)) % 256);
      model(op, ref_mem[ea], wd, e_resp, e_carry, e_new, e_lat);
      run_req(op, base, off, wd, lat, rc, wc, rcy, wcy, ov, rn, ra, wa, wdv, rd, cy);
      ref_mem[ea] = e_new;
      n_tests++;
      if (lat !== e_lat || rn !== 1) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got lat=%0d resps=%0d expected %0d/1", i, lat, rn, e_lat);
      end
      n_tests++;
      if (rd !== e_resp || cy !== e_carry) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: op=%0d got %h/%b expected %h/%b", i, op, rd, cy, e_resp, e_carry);
      end
      n_tests++;
      if (rc !== ((op == OP_STORE) ? 0 : 1) || wc !== ((op == OP_LOAD) ? 0 : 1) || ov !== 0) begin
        n_fail++;
        $display("FAIL rand_strobes[%0d]: op=%0d got rd=%0d wr=%0d ov=%0d", i, op, rc, wc, ov);
      end
      n_tests++;
      if ((rc != 0 && ra !== ea) || (wc != 0 && wa !== ea)) begin
        n_fail++;
        $display("FAIL rand_addr[%0d]: got rd=%h wr=%h expected %h", i, ra, wa, ea);
      end
      n_tests++;
      if (mem[ea] !== e_new) begin
        n_fail++;
        $display("FAIL rand_mem[%0d]: got %h expected %h at %h", i, mem[ea], e_new, ea);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
    test_reset();
    test_load();
    test_store();
    test_addm();
    test_swap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
